// File: rtl/airi5c_dm_abstract_cmd_ctrl.sv
// Abstract-command sequencer: turns Access Register commands into lw/sw words for the
// program buffer, requests postexec from the debug ROM and tracks busy/cmderr.
module airi5c_dm_abstract_cmd_ctrl #(
  parameter int unsigned XPR_LEN        = 32,
  parameter logic [11:0] DATA0_ADDR     = 12'h14C,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  input  logic [31:0]        cmd_i,
  input  logic               cmderr_clr_i,
  input  logic [XPR_LEN-1:0] user_progbuf0_i,
  input  logic [XPR_LEN-1:0] user_progbuf1_i,
  input  logic               halted_i,
  input  logic               postexec_pending_i,
  input  logic               dbg_entry_i,
  input  logic               exception_i,
  output logic [XPR_LEN-1:0] progbuf0_o,
  output logic [XPR_LEN-1:0] progbuf1_o,
  output logic               postexec_req_o,
  output logic               busy_o,
  output logic [2:0]         cmderr_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_XFER_REQ, S_XFER_WAIT, S_XFER_ENTRY, S_EXEC_REQ, S_EXEC_WAIT, S_EXEC_ENTRY
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_cmd;
  logic [2:0]         r_cmderr;
  logic               r_busy;
  logic               r_req;
  logic [XPR_LEN-1:0] r_progbuf0, r_progbuf1;
  logic [TW-1:0]      r_timer, w_timer_nxt;
  logic               r_pend_seen, w_pend_seen_nxt;
  logic               w_err_set;
  logic [2:0]         w_err_code;

  logic [7:0]  w_cmdtype;
  logic [2:0]  w_aarsize;
  logic        w_postexec, w_transfer, w_write;
  logic [15:0] w_regno;
  logic [4:0]  w_n;
  logic        w_regno_ok;
  logic [31:0] w_xfer_insn;
  logic        w_wait, w_entry, w_active, w_timeout, w_gen;

  assign w_cmdtype  = r_cmd[31:24];
  assign w_aarsize  = r_cmd[22:20];
  assign w_postexec = r_cmd[18];
  assign w_transfer = r_cmd[17];
  assign w_write    = r_cmd[16];
  assign w_regno    = r_cmd[15:0];
  assign w_n        = w_regno[4:0];
  assign w_regno_ok = (w_regno >= 16'h1000) && (w_regno <= 16'h101F);

  // write moves data0 into the GPR (lw), read moves the GPR into data0 (sw)
  assign w_xfer_insn = w_write ? {DATA0_ADDR, 5'd0, 3'b010, w_n, 7'b0000011}
                               : {DATA0_ADDR[11:5], w_n, 5'd0, 3'b010, DATA0_ADDR[4:0], 7'b0100011};

  assign w_wait    = (r_state == S_XFER_WAIT) || (r_state == S_EXEC_WAIT);
  assign w_entry   = (r_state == S_XFER_ENTRY) || (r_state == S_EXEC_ENTRY);
  assign w_active  = w_wait || w_entry;
  assign w_timeout = w_active && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_gen     = (w_state_nxt == S_XFER_REQ) || (w_state_nxt == S_XFER_WAIT) ||
                     (w_state_nxt == S_XFER_ENTRY);

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_pend_seen_nxt = r_pend_seen;
    w_err_set       = 1'b0;
    w_err_code      = 3'd0;
    case (r_state)
      S_IDLE: if (cmd_valid_i && (r_cmderr == 3'd0)) w_state_nxt = S_CHECK;
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (w_cmdtype != 8'd0) begin
          w_err_set = 1'b1; w_err_code = 3'd2;
        end else if (!halted_i) begin
          w_err_set = 1'b1; w_err_code = 3'd4;
        end else if (w_transfer && ((w_aarsize != 3'd2) || !w_regno_ok)) begin
          w_err_set = 1'b1; w_err_code = 3'd2;
        end else if (w_transfer) begin
          w_state_nxt = S_XFER_REQ;
        end else if (w_postexec) begin
          w_state_nxt = S_EXEC_REQ;
        end
      end
      S_XFER_REQ, S_EXEC_REQ: begin
        w_state_nxt     = (r_state == S_XFER_REQ) ? S_XFER_WAIT : S_EXEC_WAIT;
        w_timer_nxt     = '0;
        w_pend_seen_nxt = 1'b0;
      end
      S_XFER_WAIT, S_EXEC_WAIT: begin
        w_timer_nxt = r_timer + 1'b1;
        if (postexec_pending_i) w_pend_seen_nxt = 1'b1;
        // a trap means the ROM re-enters via ebreak, so skip straight to waiting for entry
        if ((r_pend_seen && !postexec_pending_i) || exception_i)
          w_state_nxt = (r_state == S_XFER_WAIT) ? S_XFER_ENTRY : S_EXEC_ENTRY;
      end
      S_XFER_ENTRY: begin
        w_timer_nxt = r_timer + 1'b1;
        if (dbg_entry_i)
          w_state_nxt = (w_postexec && (r_cmderr == 3'd0) && !exception_i) ? S_EXEC_REQ : S_IDLE;
      end
      S_EXEC_ENTRY: begin
        w_timer_nxt = r_timer + 1'b1;
        if (dbg_entry_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_active && exception_i) begin
      w_err_set = 1'b1; w_err_code = 3'd3;
    end
    if (w_timeout) begin
      w_err_set = 1'b1; w_err_code = 3'd3; w_state_nxt = S_IDLE;
    end
    if (!w_err_set && cmd_valid_i && r_busy) begin
      w_err_set = 1'b1; w_err_code = 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_cmderr    <= '0;
      r_busy      <= 1'b0;
      r_req       <= 1'b0;
      r_progbuf0  <= '0;
      r_progbuf1  <= '0;
      r_timer     <= '0;
      r_pend_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_req       <= (w_state_nxt == S_XFER_REQ) || (w_state_nxt == S_EXEC_REQ);
      r_timer     <= w_timer_nxt;
      r_pend_seen <= w_pend_seen_nxt;
      if ((r_state == S_IDLE) && cmd_valid_i && (r_cmderr == 3'd0)) r_cmd <= cmd_i;
      if (w_err_set && ((r_cmderr == 3'd0) || cmderr_clr_i)) r_cmderr <= w_err_code;
      else if (cmderr_clr_i)                                  r_cmderr <= '0;
      if (w_gen) begin
        r_progbuf0 <= XPR_LEN'(w_xfer_insn);
        r_progbuf1 <= XPR_LEN'(32'h0000_0013);
      end else begin
        r_progbuf0 <= user_progbuf0_i;
        r_progbuf1 <= user_progbuf1_i;
      end
    end
  end

  assign progbuf0_o     = r_progbuf0;
  assign progbuf1_o     = r_progbuf1;
  assign postexec_req_o = r_req;
  assign busy_o         = r_busy;
  assign cmderr_o       = r_cmderr;

endmodule

// File: tb/tb_airi5c_dm_abstract_cmd_ctrl.sv
// Bench for the abstract-command sequencer: directed vector table, hand sequences for
// reset/ignore corners, and random commands against a command-level prediction model.
module tb_airi5c_dm_abstract_cmd_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic [31:0] cmd_i = '0;
  logic        cmderr_clr_i = 1'b0;
  logic [31:0] user_progbuf0_i = 32'h1111_0001;
  logic [31:0] user_progbuf1_i = 32'h2222_0002;
  logic        halted_i = 1'b1;
  logic        postexec_pending_i = 1'b0;
  logic        dbg_entry_i = 1'b0;
  logic        exception_i = 1'b0;
  logic [31:0] progbuf0_o, progbuf1_o;
  logic        postexec_req_o, busy_o;
  logic [2:0]  cmderr_o;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  airi5c_dm_abstract_cmd_ctrl #(
    .XPR_LEN(32), .DATA0_ADDR(12'h14C), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .cmderr_clr_i(cmderr_clr_i), .user_progbuf0_i(user_progbuf0_i),
    .user_progbuf1_i(user_progbuf1_i), .halted_i(halted_i),
    .postexec_pending_i(postexec_pending_i), .dbg_entry_i(dbg_entry_i),
    .exception_i(exception_i), .progbuf0_o(progbuf0_o), .progbuf1_o(progbuf1_o),
    .postexec_req_o(postexec_req_o), .busy_o(busy_o), .cmderr_o(cmderr_o)
  );

  typedef struct {
    logic [31:0] cmd;
    bit          halted;
    int          exc_ph;
    bit          stuck;
    int          coll;
    logic [2:0]  err;
    int          pulses;
    bit          user_w;
    logic [31:0] w0;
  } vec_t;

  typedef struct {
    logic [2:0]  err;
    int          pulses;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          busy1;
    bit          accepted;
  } pred_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-level prediction straight from the decode and error rules
  function automatic pred_t predict(input logic [31:0] cmd, input bit halted, input logic [2:0] pre,
                                    input bit coll, input logic [31:0] u0, input logic [31:0] u1);
    pred_t p;
    int    n;
    int    regno;
    n = cmd[4:0];
    regno = cmd[15:0];
    p = '{err: pre, pulses: 0, w0: u0, w1: u1, busy1: 1'b1, accepted: 1'b1};
    if (pre != 0) begin
      p.busy1 = 1'b0; p.accepted = 1'b0;
    end else if (cmd[31:24] != 0) p.err = 3'd2;
    else if (!halted) p.err = 3'd4;
    else if (cmd[17] && (cmd[22:20] != 3'd2 || regno < 'h1000 || regno > 'h101F)) p.err = 3'd2;
    else if (cmd[17] || cmd[18]) begin
      p.busy1 = 1'b0;
      p.err = coll ? 3'd1 : 3'd0;
      if (cmd[17]) begin
        p.pulses = (cmd[18] && !coll) ? 2 : 1;
        p.w1 = 32'h13;
        if (cmd[16]) p.w0 = (32'h14C << 20) | (2 << 12) | (n << 7) | 3;
        else         p.w0 = ((32'h14C >> 5) << 25) | (n << 20) | (2 << 12) | ((32'h14C % 32) << 7) | 32'h23;
      end else p.pulses = 1;
    end
    return p;
  endfunction

  // Issue one command and play the ROM/hart side until busy drops
  task automatic run_cmd(input logic [31:0] cmd, input int exc_ph, input bit stuck, input int coll_cyc,
                         output int pulses, output logic [31:0] p0[2], output logic [31:0] p1[2],
                         output int busy_cycles, output bit timed_out);
    int ph;
    int cyc;
    pulses = 0; busy_cycles = 0; ph = -1; cyc = 0; timed_out = 1'b1;
    p0[0] = 'x; p0[1] = 'x; p1[0] = 'x; p1[1] = 'x;
    cmd_i = cmd; cmd_valid_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    while (cyc < 3000) begin
      if (!busy_o) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      if (postexec_req_o) begin
        if (pulses < 2) begin
          p0[pulses] = progbuf0_o; p1[pulses] = progbuf1_o;
        end
        pulses++; ph = 0;
      end else if (ph >= 0) ph++;
      postexec_pending_i = stuck ? (ph >= 1) : (ph >= 1 && ph <= 2);
      dbg_entry_i        = !stuck && (ph == 5);
      exception_i        = (exc_ph > 0) && (ph == exc_ph);
      cmd_valid_i        = (cyc == coll_cyc);
      if (ph >= 6) ph = -1;
      @(negedge clk_i);
      cyc++;
    end
    postexec_pending_i = 1'b0; dbg_entry_i = 1'b0; exception_i = 1'b0; cmd_valid_i = 1'b0;
  endtask

  task automatic clear_err();
    cmderr_clr_i = 1'b1;
    @(negedge clk_i);
    cmderr_clr_i = 1'b0;
    chk("cmderr_clear", {29'd0, cmderr_o}, 32'd0);
  endtask

  task automatic check_run(input string tag, input pred_t e, input int pulses, input logic [31:0] p0[2],
                           input logic [31:0] p1[2], input int busy_cycles, input bit to, input bit stuck);
    chk({tag, ".cmderr"}, {29'd0, cmderr_o}, {29'd0, e.err});
    chk({tag, ".pulses"}, pulses, e.pulses);
    chk({tag, ".no_hang"}, {31'd0, to}, 32'd0);
    if (e.pulses > 0) begin
      chk({tag, ".progbuf0"}, p0[0], e.w0);
      chk({tag, ".progbuf1"}, p1[0], e.w1);
    end
    if (e.pulses > 1) begin
      chk({tag, ".exec_progbuf0"}, p0[1], user_progbuf0_i);
      chk({tag, ".exec_progbuf1"}, p1[1], user_progbuf1_i);
    end
    if (e.accepted && e.busy1) chk({tag, ".busy_len"}, busy_cycles, 1);
    if (!e.accepted) chk({tag, ".ignored_busy"}, busy_cycles, 0);
    if (stuck) chk({tag, ".timeout_len"}, {31'd0, (busy_cycles >= 1024 && busy_cycles <= 1030)}, 32'd1);
    chk({tag, ".idle_progbuf0"}, progbuf0_o, user_progbuf0_i);
  endtask

  initial begin
    vec_t        tbl[15];
    pred_t       e;
    int          pulses, bc, cnt;
    bit          to;
    logic [31:0] p0[2], p1[2];
    logic [2:0]  m_err;
    logic [31:0] cmd;
    bit          coll;

    tbl[0]  = '{32'h0023_1005, 1, -1, 0, -1, 3'd0, 1, 0, 32'h14C0_2283};
    tbl[1]  = '{32'h0026_100A, 1, -1, 0, -1, 3'd0, 2, 0, 32'h14A0_2623};
    tbl[2]  = '{32'h0023_1005, 0, -1, 0, -1, 3'd4, 0, 0, 32'h0};
    tbl[3]  = '{32'h0023_2000, 1, -1, 0, -1, 3'd2, 0, 0, 32'h0};
    tbl[4]  = '{32'h0123_1005, 1, -1, 0, -1, 3'd2, 0, 0, 32'h0};
    tbl[5]  = '{32'h0033_1005, 1, -1, 0, -1, 3'd2, 0, 0, 32'h0};
    tbl[6]  = '{32'h0023_101F, 1, -1, 0, -1, 3'd0, 1, 0, 32'h14C0_2F83};
    tbl[7]  = '{32'h0023_1020, 1, -1, 0, -1, 3'd2, 0, 0, 32'h0};
    tbl[8]  = '{32'h0023_0FFF, 1, -1, 0, -1, 3'd2, 0, 0, 32'h0};
    tbl[9]  = '{32'h0004_0000, 1, -1, 0, -1, 3'd0, 1, 1, 32'h0};
    tbl[10] = '{32'h0000_0000, 1, -1, 0, -1, 3'd0, 0, 0, 32'h0};
    tbl[11] = '{32'h0023_1005, 1, -1, 0,  3, 3'd1, 1, 0, 32'h14C0_2283};
    tbl[12] = '{32'h0026_100A, 1,  2, 0, -1, 3'd3, 1, 0, 32'h14A0_2623};
    tbl[13] = '{32'h0023_1005, 1, -1, 1, -1, 3'd3, 1, 0, 32'h14C0_2283};
    tbl[14] = '{32'h0026_1001, 0, -1, 0, -1, 3'd4, 0, 0, 32'h0};

    repeat (3) @(negedge clk_i);
    chk("reset.busy", {31'd0, busy_o}, 32'd0);
    chk("reset.cmderr", {29'd0, cmderr_o}, 32'd0);
    chk("reset.req", {31'd0, postexec_req_o}, 32'd0);
    chk("reset.progbuf0", progbuf0_o, 32'd0);
    chk("reset.progbuf1", progbuf1_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    foreach (tbl[i]) begin
      clear_err();
      halted_i = tbl[i].halted;
      run_cmd(tbl[i].cmd, tbl[i].exc_ph, tbl[i].stuck, tbl[i].coll, pulses, p0, p1, bc, to);
      e.err = tbl[i].err; e.pulses = tbl[i].pulses;
      e.w0 = tbl[i].user_w ? user_progbuf0_i : tbl[i].w0;
      e.w1 = tbl[i].user_w ? user_progbuf1_i : 32'h13;
      e.accepted = 1'b1;
      e.busy1 = (tbl[i].pulses == 0);
      check_run($sformatf("vec%0d", i), e, pulses, p0, p1, bc, to, tbl[i].stuck);
      halted_i = 1'b1;
    end

    // A command arriving while cmderr is set must be ignored entirely
    clear_err();
    halted_i = 1'b0;
    run_cmd(32'h0023_1005, -1, 0, -1, pulses, p0, p1, bc, to);
    halted_i = 1'b1;
    run_cmd(32'h0023_1005, -1, 0, -1, pulses, p0, p1, bc, to);
    chk("ignore.cmderr", {29'd0, cmderr_o}, 32'd4);
    chk("ignore.pulses", pulses, 0);
    chk("ignore.busy", bc, 0);

    // Reset during EXEC_WAIT clears everything, including a sticky error
    clear_err();
    user_progbuf0_i = 32'hA5A5_0013; user_progbuf1_i = 32'h5A5A_0013;
    cmd_i = 32'h0004_0000; cmd_valid_i = 1'b1;
    @(negedge clk_i); cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_seq.req", {31'd0, postexec_req_o}, 32'd1);
    chk("rst_seq.req_progbuf0", progbuf0_o, 32'hA5A5_0013);
    postexec_pending_i = 1'b1;
    @(negedge clk_i); cmd_valid_i = 1'b1;
    @(negedge clk_i); cmd_valid_i = 1'b0;
    chk("rst_seq.collision_err", {29'd0, cmderr_o}, 32'd1);
    chk("rst_seq.busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_seq.busy0", {31'd0, busy_o}, 32'd0);
    chk("rst_seq.cmderr0", {29'd0, cmderr_o}, 32'd0);
    chk("rst_seq.req0", {31'd0, postexec_req_o}, 32'd0);
    chk("rst_seq.progbuf0", progbuf0_o, 32'd0);
    chk("rst_seq.progbuf1", progbuf1_o, 32'd0);
    rst_i = 1'b0; postexec_pending_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (postexec_req_o || busy_o) cnt++;
    end
    chk("rst_seq.quiet", cnt, 0);

    // Random commands checked against the prediction model
    m_err = cmderr_o === 3'd0 ? 3'd0 : 3'd7;
    clear_err(); m_err = 3'd0;
    for (int it = 0; it < 60; it++) begin
      user_progbuf0_i = $urandom; user_progbuf1_i = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        clear_err(); m_err = 3'd0;
      end else @(negedge clk_i);
      cmd = '0;
      cmd[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      cmd[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
      cmd[18] = 1'($urandom); cmd[17] = 1'($urandom); cmd[16] = 1'($urandom);
      cmd[15:0] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'('h0FFC + $urandom_range(0, 40));
      halted_i = ($urandom_range(0, 7) != 0);
      coll = ($urandom_range(0, 5) == 0);
      e = predict(cmd, halted_i, m_err, coll, user_progbuf0_i, user_progbuf1_i);
      run_cmd(cmd, -1, 0, coll ? 3 : -1, pulses, p0, p1, bc, to);
      check_run($sformatf("rand%0d", it), e, pulses, p0, p1, bc, to, 0);
      m_err = e.err;
      halted_i = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/airi5c_dm_abstract_cmd_ctrl.md
# airi5c_dm_abstract_cmd_ctrl

Abstract-command sequencer of the debug module. It decodes RISC-V debug 0.13 "Access Register" commands written over DMI into load/store instructions in the debug ROM's program-buffer slots. It then drives the ROM's postexec request and tracks the hart through execution and re-entry into the ROM park loop. It reports busy/cmderr to the DMI register file, and the user program buffer is passed through when no transfer is in flight.

## Interface
- XPR_LEN, 32: data/instruction width.
- DATA0_ADDR, 12'h14C: debug-memory byte address of data0, used as the load/store immediate.
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for one execution phase.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  one-cycle strobe when DMI writes the command register.
- cmd_i  in  32  command: cmdtype[31:24], aarsize[22:20], postexec[18], transfer[17], write[16], regno[15:0].
- cmderr_clr_i  in  1  W1C strobe that clears cmderr.
- user_progbuf0_i / user_progbuf1_i  in  XPR_LEN  debugger program buffer.
- halted_i  in  1  ROM halted flag.
- postexec_pending_i  in  1  ROM postexec status bit.
- dbg_entry_i  in  1  one-cycle pulse when the hart fetches the ROM entry word.
- exception_i  in  1  hart trapped while executing in debug mode.
- progbuf0_o / progbuf1_o  out  XPR_LEN  words fed to the ROM program-buffer slots.
- postexec_req_o  out  1  one-cycle request to the ROM.
- busy_o  out  1  abstractcs.busy.
- cmderr_o  out  3  abstractcs.cmderr; sticky.

## Operation
- States: IDLE, CHECK, XFER_REQ, XFER_WAIT, XFER_ENTRY, EXEC_REQ, EXEC_WAIT, EXEC_ENTRY.
- IDLE:
  - cmd_valid_i with cmderr_o==0 latches cmd_i and goes to CHECK.
  - cmd_valid_i with cmderr_o!=0 is ignored.
- CHECK, evaluated in this order:
  - cmdtype!=0 -> cmderr=2, back to IDLE.
  - !halted_i -> cmderr=4, IDLE.
  - transfer=1 with aarsize!=2 or regno outside 0x1000..0x101F -> cmderr=2, IDLE.
  - Otherwise, transfer=1 -> XFER_REQ; transfer=0 with postexec=1 -> EXEC_REQ; neither -> IDLE with no error.
- Transfer instruction, n=regno[4:0]:
  - write=1: lw xn,DATA0_ADDR(x0) = {DATA0_ADDR, 5'd0, 3'b010, n, 7'b0000011}.
  - write=0: sw xn,DATA0_ADDR(x0) = {DATA0_ADDR[11:5], n, 5'd0, 3'b010, DATA0_ADDR[4:0], 7'b0100011}.
  - progbuf1_o = 32'h00000013 (nop). Generated words are held from XFER_REQ through XFER_ENTRY.
  - In all other states, progbuf0/1_o = user_progbuf0/1_i, registered.
- XFER_REQ / EXEC_REQ: assert postexec_req_o for one cycle, then go to the matching *_WAIT state.
- *_WAIT:
  - Wait until postexec_pending_i has been seen high and then low (the ROM cleared it and entered the program buffer).
  - Then move to *_ENTRY.
- *_ENTRY:
  - dbg_entry_i with halted re-entry ends the phase.
  - XFER_ENTRY goes to EXEC_REQ if postexec=1 and cmderr is still 0; otherwise to IDLE.
  - EXEC_ENTRY goes to IDLE.
- exception_i in any WAIT or ENTRY state sets cmderr=3 (if cmderr was 0). The sequencer still waits for dbg_entry_i, because the ROM re-enters via the implicit ebreak. The exec phase is skipped afterwards.
- Timeout:
  - The counter resets on each *_REQ.
  - Reaching TIMEOUT_CYCLES in a WAIT or ENTRY state sets cmderr=3 and goes straight to IDLE.
- cmd_valid_i while busy_o=1 sets cmderr=1 (if cmderr was 0); the running command continues unchanged.
- cmderr_clr_i clears cmderr_o to 0.
  - If it coincides with an error-setting event, the set wins.
  - It has no effect on the FSM.

## Timing
- Reset values: state=IDLE, busy_o=0, cmderr_o=0, postexec_req_o=0, progbuf0/1_o=0, timeout counter=0.
- busy_o is high in every state except IDLE. It rises the cycle after the accepted cmd_valid_i and falls the cycle the FSM re-enters IDLE.
- CHECK takes 1 cycle. Minimum postexec_req_o assertion is 2 cycles after cmd_valid_i.
- progbuf0_o carries the generated instruction no later than the cycle postexec_req_o is high.
- Error-only commands keep busy_o high for exactly 1 cycle (CHECK) and set cmderr_o in the same cycle busy_o falls.
- All outputs are registered; no combinational input-to-output paths.
- Reset asserted mid-command returns to the reset state on the next edge; no postexec pulse follows.

## Test plan
- GPR write: halted_i=1, cmd=0x00231005 (aarsize 2, transfer, write, x5). Expect progbuf0_o=0x14C02283, one postexec_req_o pulse. Model the ROM pending high/low and then dbg_entry_i; busy_o then falls and cmderr_o=0.
- GPR read plus postexec: cmd=0x0026100A. Expect sw x10 = 0x14A02623 and a first pulse. After entry, expect progbuf0_o to return to the user word and a second pulse. busy_o falls after the second entry.
- Errors:
  - Hart not halted: halted_i=0 -> cmderr_o=4, no pulse.
  - regno=0x2000 -> cmderr_o=2.
  - cmdtype=1 -> cmderr_o=2.
- Busy collision: a second cmd_valid_i during XFER_WAIT -> cmderr_o=1, first command completes. Then cmderr_clr_i -> 0.
- Exception: exception_i during XFER_WAIT with postexec=1 -> cmderr_o=3, no second pulse, IDLE after dbg_entry_i.
- Timeout / reset: never drop postexec_pending_i -> cmderr_o=3 and busy_o low after 1024 cycles. Separately, assert rst_i in EXEC_WAIT -> all outputs 0 on the next cycle.
